// File: rtl/csi_pkg.sv
// Shared constants and state type for the CSI-2 packet parser.
package csi_pkg;

  localparam logic [5:0] DT_FS     = 6'h00;
  localparam logic [5:0] DT_FE     = 6'h01;
  localparam logic [5:0] DT_LS     = 6'h02;
  localparam logic [5:0] DT_LE     = 6'h03;
  localparam logic [5:0] DT_RAW8   = 6'h2A;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CRC     = 2'd3
  } csi_state_e;

endpackage

// File: rtl/csi_pkt_parser.sv
// Single-lane CSI-2 packet parser: header decode, short-packet markers,
// payload streaming and raw CRC capture after sync detection.
//
//   state   | meaning
//   IDLE    | waiting for sync_found while the lane is in HS
//   HDR     | collecting DI, WC LSB, WC MSB, ECC
//   PAYLOAD | streaming WC payload bytes
//   CRC     | collecting CRC LSB then MSB
module csi_pkt_parser
  import csi_pkg::*;
#(
  parameter logic [15:0] MAX_WC      = 16'd4096,
  parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hs_active,
  input  logic        i_sync_found,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_vld,
  output logic [7:0]  o_pix_data,
  output logic        o_pix_vld,
  output logic        o_hdr_vld,
  output logic [1:0]  o_virt_ch,
  output logic [5:0]  o_data_type,
  output logic [15:0] o_word_count,
  output logic [7:0]  o_ecc,
  output logic        o_frame_start,
  output logic        o_frame_end,
  output logic        o_line_start,
  output logic        o_line_end,
  output logic [15:0] o_pkt_crc,
  output logic        o_crc_vld,
  output logic        o_hdr_err,
  output logic        o_pkt_abort
);

  csi_state_e  r_state;
  csi_state_e  w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [15:0] r_rem;
  logic [15:0] w_rem_nxt;
  logic [7:0]  r_di;
  logic [7:0]  r_wc_lsb;
  logic [7:0]  r_wc_msb;
  logic [7:0]  r_crc_lsb;

  logic [15:0] w_wc;
  logic [5:0]  w_dt;
  logic        w_accept;
  logic        w_hdr_done;
  logic        w_hdr_err;
  logic        w_pix;
  logic        w_crc_done;
  logic        w_abort;
  logic [3:0]  w_mark;

  assign w_wc     = {r_wc_msb, r_wc_lsb};
  assign w_dt     = r_di[5:0];
  assign w_accept = i_hs_active & i_byte_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_rem   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_hdr_done  = 1'b0;
    w_hdr_err   = 1'b0;
    w_pix       = 1'b0;
    w_crc_done  = 1'b0;
    w_abort     = 1'b0;
    w_mark      = 4'b0000;
    // Losing HS anywhere inside a packet drops the byte and returns to IDLE.
    if (r_state != IDLE && !i_hs_active) begin
      w_state_nxt = IDLE;
      w_abort     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_sync_found && i_hs_active) begin
            w_state_nxt = HDR;
            w_cnt_nxt   = 2'd0;
          end
        end
        HDR: begin
          if (i_byte_vld) begin
            w_cnt_nxt = r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              w_hdr_done = 1'b1;
              if (w_dt < LONG_DT_MIN) begin
                w_state_nxt = IDLE;
                case (w_dt)
                  DT_FS:   w_mark[0] = 1'b1;
                  DT_FE:   w_mark[1] = 1'b1;
                  DT_LS:   w_mark[2] = 1'b1;
                  DT_LE:   w_mark[3] = 1'b1;
                  default: w_mark    = 4'b0000;
                endcase
              end else if (w_wc > MAX_WC) begin
                w_hdr_err   = 1'b1;
                w_state_nxt = IDLE;
              end else if (w_wc == 16'd0) begin
                w_state_nxt = CRC;
                w_cnt_nxt   = 2'd0;
              end else begin
                w_rem_nxt   = w_wc;
                w_state_nxt = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (i_byte_vld) begin
            w_pix     = 1'b1;
            w_rem_nxt = r_rem - 16'd1;
            if (r_rem == 16'd1) begin
              w_state_nxt = CRC;
              w_cnt_nxt   = 2'd0;
            end
          end
        end
        CRC: begin
          if (i_byte_vld) begin
            if (r_cnt == 2'd0) begin
              w_cnt_nxt = 2'd1;
            end else begin
              w_crc_done  = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_di          <= 8'd0;
      r_wc_lsb      <= 8'd0;
      r_wc_msb      <= 8'd0;
      r_crc_lsb     <= 8'd0;
      o_pix_data    <= 8'd0;
      o_pix_vld     <= 1'b0;
      o_hdr_vld     <= 1'b0;
      o_virt_ch     <= 2'd0;
      o_data_type   <= 6'd0;
      o_word_count  <= 16'd0;
      o_ecc         <= 8'd0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_line_start  <= 1'b0;
      o_line_end    <= 1'b0;
      o_pkt_crc     <= 16'd0;
      o_crc_vld     <= 1'b0;
      o_hdr_err     <= 1'b0;
      o_pkt_abort   <= 1'b0;
    end else begin
      if (r_state == HDR && w_accept) begin
        case (r_cnt)
          2'd0:    r_di     <= i_byte_in;
          2'd1:    r_wc_lsb <= i_byte_in;
          2'd2:    r_wc_msb <= i_byte_in;
          default: ;
        endcase
      end
      if (r_state == CRC && w_accept && r_cnt == 2'd0) begin
        r_crc_lsb <= i_byte_in;
      end
      o_pix_vld <= w_pix;
      if (w_pix) begin
        o_pix_data <= i_byte_in;
      end
      o_hdr_vld <= w_hdr_done;
      if (w_hdr_done) begin
        o_virt_ch    <= r_di[7:6];
        o_data_type  <= w_dt;
        o_word_count <= w_wc;
        o_ecc        <= i_byte_in;
      end
      o_crc_vld <= w_crc_done;
      if (w_crc_done) begin
        o_pkt_crc <= {i_byte_in, r_crc_lsb};
      end
      o_frame_start <= w_mark[0];
      o_frame_end   <= w_mark[1];
      o_line_start  <= w_mark[2];
      o_line_end    <= w_mark[3];
      o_hdr_err     <= w_hdr_err;
      o_pkt_abort   <= w_abort;
    end
  end

endmodule

// File: tb/tb_csi_pkt_parser.sv
// Directed bench for csi_pkt_parser: a packet-level model checked every cycle
// plus literal per-scenario expectations.
module tb_csi_pkt_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_active = 1'b0;
  logic        sync_found = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_vld = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_vld;
  logic        hdr_vld;
  logic [1:0]  virt_ch;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        frame_start, frame_end, line_start, line_end;
  logic [15:0] pkt_crc;
  logic        crc_vld;
  logic        hdr_err;
  logic        pkt_abort;

  csi_pkt_parser dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hs_active  (hs_active),
    .i_sync_found (sync_found),
    .i_byte_in    (byte_in),
    .i_byte_vld   (byte_vld),
    .o_pix_data   (pix_data),
    .o_pix_vld    (pix_vld),
    .o_hdr_vld    (hdr_vld),
    .o_virt_ch    (virt_ch),
    .o_data_type  (data_type),
    .o_word_count (word_count),
    .o_ecc        (ecc),
    .o_frame_start(frame_start),
    .o_frame_end  (frame_end),
    .o_line_start (line_start),
    .o_line_end   (line_end),
    .o_pkt_crc    (pkt_crc),
    .o_crc_vld    (crc_vld),
    .o_hdr_err    (hdr_err),
    .o_pkt_abort  (pkt_abort)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Packet-level model: bytes of the current packet are kept in a queue and
  // every output follows from the queue length and the decoded header.
  bit         m_in_pkt;
  logic [7:0] m_q[$];
  logic [7:0]  e_pix_data;
  logic        e_pix_vld, e_hdr_vld, e_fs, e_fe, e_ls, e_le, e_crc_vld, e_err, e_abort;
  logic [1:0]  e_vc;
  logic [5:0]  e_dt;
  logic [15:0] e_wc;
  logic [7:0]  e_ecc;
  logic [15:0] e_crc;

  int ev_pix, ev_hdr, ev_fs, ev_fe, ev_ls, ev_le, ev_crc, ev_err, ev_abort;
  logic [7:0] pix_log[$];
  logic [7:0] tx[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void clear_pulses();
    e_pix_vld = 0; e_hdr_vld = 0; e_fs = 0; e_fe = 0; e_ls = 0; e_le = 0;
    e_crc_vld = 0; e_err = 0; e_abort = 0;
  endfunction

  function automatic void model_reset();
    clear_pulses();
    m_in_pkt = 0;
    m_q.delete();
    e_pix_data = 0; e_vc = 0; e_dt = 0; e_wc = 0; e_ecc = 0; e_crc = 0;
  endfunction

  function automatic void model_step();
    int n;
    int wc;
    clear_pulses();
    if (!m_in_pkt) begin
      if (sync_found && hs_active) begin
        m_in_pkt = 1;
        m_q.delete();
      end
    end else if (!hs_active) begin
      m_in_pkt = 0;
      e_abort = 1;
    end else if (byte_vld) begin
      m_q.push_back(byte_in);
      n = m_q.size();
      wc = (n >= 4) ? int'({m_q[2], m_q[1]}) : 0;
      if (n == 4) begin
        e_hdr_vld = 1;
        e_vc = m_q[0][7:6];
        e_dt = m_q[0][5:0];
        e_wc = 16'(wc);
        e_ecc = m_q[3];
        if (e_dt < 6'h10) begin
          e_fs = (e_dt == 6'h00);
          e_fe = (e_dt == 6'h01);
          e_ls = (e_dt == 6'h02);
          e_le = (e_dt == 6'h03);
          m_in_pkt = 0;
        end else if (wc > 4096) begin
          e_err = 1;
          m_in_pkt = 0;
        end
      end else if (n > 4 && n <= 4 + wc) begin
        e_pix_vld = 1;
        e_pix_data = byte_in;
      end else if (n == 4 + wc + 2) begin
        e_crc_vld = 1;
        e_crc = {byte_in, m_q[n-2]};
        m_in_pkt = 0;
      end
    end
  endfunction

  task automatic cyc(input logic hs, input logic sy, input logic vld, input logic [7:0] b);
    hs_active = hs; sync_found = sy; byte_vld = vld; byte_in = b;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int gap);
    cyc(1, 1, 0, 8'h00);
    foreach (tx[i]) begin
      cyc(1, 0, 1, tx[i]);
      for (int g = 0; g < gap; g++) cyc(1, (g == 0), 0, 8'hEE);
    end
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask

  initial begin
    int p0, c0, h0, f0, e0, a0, l0, m0;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) model_reset();
        check("pix_vld", pix_vld, e_pix_vld);
        check("pix_data", pix_data, e_pix_data);
        check("hdr_vld", hdr_vld, e_hdr_vld);
        check("virt_ch", virt_ch, e_vc);
        check("data_type", data_type, e_dt);
        check("word_count", word_count, e_wc);
        check("ecc", ecc, e_ecc);
        check("markers", {frame_start, frame_end, line_start, line_end}, {e_fs, e_fe, e_ls, e_le});
        check("crc_vld", crc_vld, e_crc_vld);
        check("pkt_crc", pkt_crc, e_crc);
        check("hdr_err", hdr_err, e_err);
        check("pkt_abort", pkt_abort, e_abort);
        if (rst_n) begin
          if (pix_vld) begin ev_pix++; pix_log.push_back(pix_data); end
          ev_hdr += int'(hdr_vld); ev_fs += int'(frame_start); ev_fe += int'(frame_end);
          ev_ls += int'(line_start); ev_le += int'(line_end); ev_crc += int'(crc_vld);
          ev_err += int'(hdr_err); ev_abort += int'(pkt_abort);
          model_step();
        end
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("rst word_count", word_count, 16'h0000);
        check("rst pkt_crc", pkt_crc, 16'h0000);
        rst_n = 1'b1;
        cyc(0, 0, 0, 8'h00);

        // FS short packet
        p0 = ev_pix; h0 = ev_hdr; f0 = ev_fs;
        tx = '{8'h00, 8'h01, 8'h00, 8'h5A};
        send(0);
        check("fs count", ev_fs - f0, 1);
        check("fs hdr count", ev_hdr - h0, 1);
        check("fs no pix", ev_pix - p0, 0);
        check("fs word_count", word_count, 16'h0001);
        check("fs virt_ch", virt_ch, 2'd0);

        // RAW8 long packet, then the same with stalls and stray sync pulses
        for (int s = 0; s < 2; s++) begin
          p0 = ev_pix; c0 = ev_crc; l0 = pix_log.size();
          tx = '{8'h2A, 8'h04, 8'h00, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'hCD, 8'hAB};
          send(s * 2);
          check("raw8 pix count", ev_pix - p0, 4);
          check("raw8 pix0", pix_log[l0], 8'h11);
          check("raw8 pix1", pix_log[l0+1], 8'h22);
          check("raw8 pix2", pix_log[l0+2], 8'h33);
          check("raw8 pix3", pix_log[l0+3], 8'h44);
          check("raw8 crc count", ev_crc - c0, 1);
          check("raw8 pkt_crc", pkt_crc, 16'hABCD);
          check("raw8 virt_ch", virt_ch, 2'd0);
        end

        // Zero word count
        p0 = ev_pix; c0 = ev_crc;
        tx = '{8'h2A, 8'h00, 8'h00, 8'h07, 8'h34, 8'h12};
        send(0);
        check("wc0 no pix", ev_pix - p0, 0);
        check("wc0 crc count", ev_crc - c0, 1);
        check("wc0 pkt_crc", pkt_crc, 16'h1234);

        // Oversize WC, trailing bytes ignored, then a normal VC1 packet
        p0 = ev_pix; e0 = ev_err;
        tx = '{8'h2A, 8'h01, 8'h10, 8'h00, 8'h99, 8'h98};
        send(0);
        check("oversize err", ev_err - e0, 1);
        check("oversize no pix", ev_pix - p0, 0);
        check("oversize word_count", word_count, 16'h1001);
        p0 = ev_pix; l0 = pix_log.size();
        tx = '{8'h6A, 8'h02, 8'h00, 8'h11, 8'h55, 8'h66, 8'hEF, 8'hBE};
        send(0);
        check("vc1 pix count", ev_pix - p0, 2);
        check("vc1 pix0", pix_log[l0], 8'h55);
        check("vc1 pix1", pix_log[l0+1], 8'h66);
        check("vc1 virt_ch", virt_ch, 2'd1);
        check("vc1 pkt_crc", pkt_crc, 16'hBEEF);

        // LE on VC3, then a generic short packet that pulses no marker
        m0 = ev_fs + ev_fe + ev_ls + ev_le; h0 = ev_hdr;
        tx = '{8'hC3, 8'h07, 8'h00, 8'h22};
        send(0);
        check("le count", ev_fs + ev_fe + ev_ls + ev_le - m0, 1);
        check("le virt_ch", virt_ch, 2'd3);
        check("le data_type", data_type, 6'h03);
        m0 = ev_fs + ev_fe + ev_ls + ev_le;
        tx = '{8'h08, 8'h00, 8'h00, 8'h33};
        send(0);
        check("generic no marker", ev_fs + ev_fe + ev_ls + ev_le - m0, 0);
        check("generic hdr count", ev_hdr - h0, 2);

        // HS drop after two of four payload bytes
        p0 = ev_pix; c0 = ev_crc; a0 = ev_abort;
        cyc(1, 1, 0, 8'h00);
        tx = '{8'h2A, 8'h04, 8'h00, 8'h3C, 8'h11, 8'h22};
        foreach (tx[i]) cyc(1, 0, 1, tx[i]);
        cyc(0, 0, 1, 8'h33);
        cyc(0, 0, 1, 8'h44);
        cyc(1, 0, 1, 8'hCD);
        cyc(1, 0, 1, 8'hAB);
        cyc(0, 0, 0, 8'h00);
        check("drop abort", ev_abort - a0, 1);
        check("drop pix count", ev_pix - p0, 2);
        check("drop no crc", ev_crc - c0, 0);

        // Asynchronous reset mid-payload
        cyc(1, 1, 0, 8'h00);
        tx = '{8'h2A, 8'h04, 8'h00, 8'h3C, 8'h11, 8'h22};
        foreach (tx[i]) cyc(1, 0, 1, tx[i]);
        rst_n = 1'b0;
        #1;
        check("arst pix_vld", pix_vld, 1'b0);
        check("arst word_count", word_count, 16'h0000);
        check("arst data_type", data_type, 6'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        rst_n = 1'b1;
        p0 = ev_pix; c0 = ev_crc; h0 = ev_hdr;
        tx = '{8'h33, 8'h44, 8'hCD, 8'hAB, 8'h2A, 8'h01, 8'h00, 8'h00};
        foreach (tx[i]) cyc(1, 0, 1, tx[i]);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        check("post-rst no pix", ev_pix - p0, 0);
        check("post-rst no hdr", ev_hdr - h0, 0);
        check("post-rst no crc", ev_crc - c0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join
  end

endmodule
